// File: rtl/mem_preload_sequencer_if.sv
// Memory write port shared by the preload sequencer and the CPU's external
// data-memory write path. The master drives the write; the slave answers ready.
interface mem_preload_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/mem_preload_sequencer.sv
// Memory preload sequencer.
// Holds the CPU in reset, writes NUM_WORDS words starting at BASE_ADDR (the
// first NUM_VALS words carry the point values latched at start, the rest are
// zero), then releases the CPU. Each write waits for mem_ready, is followed by
// GAP_CYCLES idle cycles, and is abandoned with a sticky error if ready stays
// low for TIMEOUT consecutive cycles.
module mem_preload_sequencer #(
  parameter int          ADDR_W     = 32,
  parameter int          DATA_W     = 32,
  parameter int          PT_W       = 5,
  parameter int          NUM_VALS   = 2,
  parameter int          NUM_WORDS  = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h02000000,
  parameter int          STRIDE     = 4,
  parameter int          GAP_CYCLES = 1,
  parameter int          TIMEOUT    = 255
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [NUM_VALS*PT_W-1:0]           pt_data,
  mem_preload_sequencer_if.master            mem_bus,
  output logic                               cpu_reset,
  output logic                               busy,
  output logic                               done,
  output logic                               err,
  output logic [$clog2(NUM_WORDS+1)-1:0]     word_idx
);

  localparam int IDX_W   = $clog2(NUM_WORDS + 1);
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W   = $clog2(GAP_CYCLES + 2);

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_WORDS - 1);
  // The stall counter holds the number of stalled cycles already seen, so the
  // TIMEOUT-th stalled cycle is the one where it reads TIMEOUT-1.
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]               r_state;
  logic                     r_cpu_reset;
  logic                     r_err;
  logic [IDX_W-1:0]         r_word_idx;
  logic [STALL_W-1:0]       r_stall;
  logic [GAP_W-1:0]         r_gap;
  logic [NUM_VALS*PT_W-1:0] r_pt;

  logic                     w_in_write;
  logic [ADDR_W-1:0]        w_addr;
  logic [DATA_W-1:0]        w_val_data;
  logic [PT_W-1:0]          w_vals [NUM_VALS];

  // Split the latched point bus into one value per word slot.
  for (genvar gi = 0; gi < NUM_VALS; gi++) begin : g_unpack
    assign w_vals[gi] = r_pt[gi*PT_W +: PT_W];
  end

  // Sequencer state, word/stall/gap counters, latched values and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cpu_reset <= 1'b1;
      r_err       <= 1'b0;
      r_word_idx  <= '0;
      r_stall     <= '0;
      r_gap       <= '0;
      r_pt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cpu_reset <= 1'b0;
          if (start) begin
            r_pt        <= pt_data;
            r_err       <= 1'b0;
            r_word_idx  <= '0;
            r_stall     <= '0;
            r_cpu_reset <= 1'b1;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (mem_bus.mem_ready) begin
            r_stall <= '0;
            if (GAP_CYCLES > 0) begin
              r_gap   <= '0;
              r_state <= S_GAP;
            end else if (r_word_idx == LAST_IDX) begin
              r_state <= S_DONE;
            end else begin
              r_word_idx <= r_word_idx + IDX_W'(1);
            end
          end else if (r_stall == STALL_LAST) begin
            // Memory never answered: abandon the remaining words.
            r_stall <= '0;
            r_err   <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_stall <= r_stall + STALL_W'(1);
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            if (r_word_idx == LAST_IDX) begin
              r_state <= S_DONE;
            end else begin
              r_word_idx <= r_word_idx + IDX_W'(1);
              r_state    <= S_WRITE;
            end
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        S_DONE: begin
          // CPU leaves reset together with the return to IDLE.
          r_cpu_reset <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_in_write = (r_state == S_WRITE);
  assign w_addr     = ADDR_W'(BASE_ADDR) + ADDR_W'(r_word_idx) * ADDR_W'(STRIDE);

  // Select the zero-extended point value for the current word, zero past NUM_VALS.
  always_comb begin
    w_val_data = '0;
    for (int k = 0; k < NUM_VALS; k++) begin
      if (r_word_idx == IDX_W'(k)) begin
        w_val_data = DATA_W'(w_vals[k]);
      end
    end
  end

  assign mem_bus.mem_we    = w_in_write;
  assign mem_bus.mem_addr  = w_in_write ? w_addr : '0;
  assign mem_bus.mem_wdata = w_in_write ? w_val_data : '0;

  assign cpu_reset = r_cpu_reset;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err       = r_err;
  assign word_idx  = r_word_idx;

endmodule

// File: doc/mem_preload_sequencer.md
Name: mem_preload_sequencer

Overview:
- Parametrised successor of the point-write controller. It holds the CPU in reset and writes a block of NUM_WORDS words into data memory through the external write port, then releases the CPU.
- The first NUM_VALS words carry zero-extended values latched from the pt_data input. The remaining words are cleared to zero.
- Adds a memory ready handshake, a configurable idle gap between writes, a stall timeout with error reporting, and a completion pulse.
- Sits between the host/command logic and the CPU's Ext_* memory write port.

Parameters:
ADDR_W, 32, width of mem_addr
DATA_W, 32, width of mem_wdata
PT_W, 5, width of each point value
NUM_VALS, 2, number of point values carried on pt_data (1..NUM_WORDS)
NUM_WORDS, 4, total words written per sequence (>=1)
BASE_ADDR, 32'h02000000, address of word 0
STRIDE, 4, byte increment between consecutive words
GAP_CYCLES, 1, idle cycles after each accepted write (0 = back-to-back)
TIMEOUT, 255, max consecutive cycles mem_ready may stay low during a write (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  request a preload sequence (sampled in IDLE only)
pt_data  in  NUM_VALS*PT_W  point values; value k is in bits [k*PT_W +: PT_W]
mem_ready  in  1  memory accepts the write on any edge where mem_we && mem_ready
cpu_reset  out  1  held-in-reset signal to CPU
mem_we  out  1  write enable
mem_addr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at end of sequence
err  out  1  sticky: last sequence aborted on timeout
word_idx  out  clog2(NUM_WORDS+1)  index of the current word

Behaviour:
- Reset, synchronous and active-high, with the following values:
  - cpu_reset = 1.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - busy = 0, done = 0, err = 0, word_idx = 0.
  - state = IDLE.
  - Reset asserted mid-sequence aborts immediately. No further writes are issued.
- States: IDLE, WRITE, GAP, DONE.
- IDLE:
  - cpu_reset = 0, mem_we = 0, addr/data = 0, busy = 0.
  - On start = 1, latch pt_data into an internal copy. Later pt_data changes have no effect.
  - Clear err and set word_idx = 0. On the next cycle: cpu_reset = 1, busy = 1, state = WRITE.
- WRITE:
  - mem_we = 1, mem_addr = BASE_ADDR + word_idx*STRIDE, truncated to ADDR_W.
  - mem_wdata = zero-extended latched value[word_idx] if word_idx < NUM_VALS, else 0.
  - Outputs are held stable until accepted.
  - Acceptance at an edge with mem_ready = 1:
    - If GAP_CYCLES > 0, go to GAP.
    - Else, if more words remain, increment word_idx and stay in WRITE, issuing the next word the following cycle.
    - Else, go to DONE.
  - Stall counter counts consecutive cycles in WRITE with mem_ready = 0 and resets on acceptance.
  - On reaching TIMEOUT: drop mem_we, set err = 1, go to DONE. The remaining words are not written.
- GAP:
  - mem_we = 0, mem_addr = 0, mem_wdata = 0 for exactly GAP_CYCLES cycles.
  - Then increment word_idx and go to WRITE, or go to DONE if the last word is complete.
- DONE (one cycle):
  - done = 1, busy = 1, cpu_reset still 1, mem_we = 0.
  - Next cycle: IDLE, so cpu_reset falls exactly one cycle after the done pulse.
- start while not in IDLE is ignored. It is not queued.
- err holds its value until the next accepted start or reset.
- Sequence length with GAP_CYCLES = G and mem_ready tied high: from start sampled to done high = 1 + NUM_WORDS*(1+G) cycles.

Test Plan:
- Defaults, mem_ready = 1, pt_data = {EP=5'd17, SP=5'd3}, start pulse:
  - Writes 3 @0x02000000, 17 @0x02000004, 0 @0x02000008, 0 @0x0200000C, each followed by one idle cycle.
  - done pulses at cycle 9 after start; cpu_reset high from cycle 1 to cycle 9, low at cycle 10; err = 0.
- GAP_CYCLES = 0, NUM_WORDS = 6, STRIDE = 8:
  - Six consecutive mem_we cycles at 0x02000000..0x02000028 step 8.
  - done exactly 7 cycles after start.
- mem_ready low for 3 cycles on word 1:
  - Address 0x02000004 and data held stable for 4 cycles, written once.
  - Sequence completes with err = 0.
- TIMEOUT = 4, mem_ready stuck low on word 2:
  - mem_we drops after 4 stalled cycles; DONE with err = 1; word 3 is never written.
  - cpu_reset releases the cycle after done.
- start re-pulsed during WRITE, and pt_data changed mid-sequence:
  - No restart; written values are those latched at the original start.
- reset asserted during GAP of word 1:
  - Next cycle all outputs are at their reset values and state is IDLE.
  - cpu_reset stays 1 while reset is high and falls the first cycle after reset is released.
